// File: rtl/atd_rx_fifo.sv
// atd_rx_fifo: assembles serial ATD bits into BLOCK_BITS-wide blocks and queues
// them in a DEPTH-entry FIFO popped by a level-to-pulse data_taken handshake.
module atd_rx_fifo #(
  parameter int BLOCK_BITS = 128,
  parameter int DEPTH      = 2,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ATD_data,
  input  logic                       ATD_clk,
  input  logic                       ATD_shift_enable,
  input  logic                       data_taken,
  input  logic                       flush,
  input  logic                       clear_err,
  output logic [BLOCK_BITS-1:0]      data_out,
  output logic                       data_ready,
  output logic [$clog2(DEPTH+1)-1:0] block_count,
  output logic                       overflow,
  output logic                       framing_err
);
  localparam int NBYTES = BLOCK_BITS / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic {ARMED = 1'b0, HELD = 1'b1} pop_state_t;

  logic [2:0]            r_bit_cnt;
  logic [BW-1:0]         r_byte_cnt;
  logic [7:0]            r_byte;
  logic [BLOCK_BITS-1:0] r_block;
  logic [BLOCK_BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  pop_state_t            r_state;
  logic                  r_overflow;
  logic                  r_framing_err;

  logic                  w_strobe;
  logic                  w_byte_done;
  logic                  w_block_done;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [7:0]            w_next_byte;
  logic [BLOCK_BITS-1:0] w_next_block;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // A strobe coinciding with flush is discarded; the FIFO keeps accepting while full only if it pops.
  assign w_strobe     = ATD_shift_enable & ~flush;
  assign w_next_byte  = LSB_FIRST ? {ATD_data, r_byte[7:1]} : {r_byte[6:0], ATD_data};
  assign w_byte_done  = w_strobe & (r_bit_cnt == 3'd7);
  assign w_block_done = w_byte_done & (r_byte_cnt == LAST_BYTE);
  assign w_pop        = (r_state == ARMED) & data_taken & (r_count != {CW{1'b0}});
  assign w_push       = w_block_done & ((r_count != FULL_CNT) | w_pop);
  assign w_drop       = w_block_done & ~w_push;

  // Block register with the completing byte merged in, first byte at the top.
  always_comb begin
    w_next_block = r_block;
    for (int b = 0; b < NBYTES; b++) begin
      if (r_byte_cnt == BW'(b)) begin
        w_next_block[BLOCK_BITS-1-8*b -: 8] = w_next_byte;
      end else begin
        w_next_block[BLOCK_BITS-1-8*b -: 8] = r_block[BLOCK_BITS-1-8*b -: 8];
      end
    end
  end

  // Bit/byte assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= {BW{1'b0}};
      r_byte     <= 8'd0;
      r_block    <= {BLOCK_BITS{1'b0}};
    end else if (flush) begin
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= {BW{1'b0}};
      r_byte     <= 8'd0;
      r_block    <= {BLOCK_BITS{1'b0}};
    end else if (w_strobe) begin
      r_byte    <= w_next_byte;
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_byte_done) begin
        r_byte_cnt <= w_block_done ? {BW{1'b0}} : r_byte_cnt + BW'(1);
        r_block    <= w_block_done ? {BLOCK_BITS{1'b0}} : w_next_block;
      end
    end
  end

  // Block FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {BLOCK_BITS{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_next_block;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pop handshake: one pop per data_taken assertion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARMED;
    end else begin
      case (r_state)
        ARMED:   r_state <= w_pop ? HELD : ARMED;
        HELD:    r_state <= data_taken ? HELD : ARMED;
        default: r_state <= ARMED;
      endcase
    end
  end

  // Sticky error flags; a set event beats clear_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow    <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_overflow    <= w_drop | (r_overflow & ~clear_err);
      r_framing_err <= (ATD_shift_enable & ~ATD_clk) | (r_framing_err & ~clear_err);
    end
  end

  assign data_ready  = (r_count != {CW{1'b0}});
  assign data_out    = data_ready ? r_mem[r_rd_ptr] : {BLOCK_BITS{1'b0}};
  assign block_count = r_count;
  assign overflow    = r_overflow;
  assign framing_err = r_framing_err;
endmodule

// File: tb/tb_atd_rx_fifo.sv
// tb_atd_rx_fifo: random and directed stimulus on two atd_rx_fifo configurations,
// checked every cycle against a queue-based model of the block FIFO.
module tb_atd_rx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic d0_dat, d0_ck, d0_se, d0_dt, d0_fl, d0_ce;
  logic [127:0] d0_out;
  logic d0_rdy, d0_ovf, d0_ferr;
  logic [1:0] d0_cnt;
  logic d1_dat, d1_ck, d1_se, d1_dt, d1_fl, d1_ce;
  logic [31:0] d1_out;
  logic d1_rdy, d1_ovf, d1_ferr;
  logic [1:0] d1_cnt;

  atd_rx_fifo dut0 (
    .clk(clk), .rst(rst), .ATD_data(d0_dat), .ATD_clk(d0_ck), .ATD_shift_enable(d0_se),
    .data_taken(d0_dt), .flush(d0_fl), .clear_err(d0_ce), .data_out(d0_out),
    .data_ready(d0_rdy), .block_count(d0_cnt), .overflow(d0_ovf), .framing_err(d0_ferr)
  );

  atd_rx_fifo #(.BLOCK_BITS(32), .DEPTH(2), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .ATD_data(d1_dat), .ATD_clk(d1_ck), .ATD_shift_enable(d1_se),
    .data_taken(d1_dt), .flush(d1_fl), .clear_err(d1_ce), .data_out(d1_out),
    .data_ready(d1_rdy), .block_count(d1_cnt), .overflow(d1_ovf), .framing_err(d1_ferr)
  );

  localparam int MDEPTH = 2;
  int n_tests = 0;
  int n_fail  = 0;
  int sel;
  int mbits;
  bit mlsb;
  bit mq[$];
  logic [127:0] mfifo[$];
  bit marmed, movf, mferr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mfifo.delete();
    marmed = 1'b1;
    movf   = 1'b0;
    mferr  = 1'b0;
  endtask

  function automatic logic [127:0] form_block();
    logic [127:0] blk;
    logic [7:0] by;
    blk = 128'd0;
    for (int k = 0; k < mbits / 8; k++) begin
      by = 8'd0;
      for (int i = 0; i < 8; i++) begin
        if (mlsb) by[i] = mq[8*k+i];
        else      by[7-i] = mq[8*k+i];
      end
      blk = blk | (128'(by) << (mbits - 8 - 8*k));
    end
    return blk;
  endfunction

  task automatic model_update(input bit se, input bit d, input bit ck, input bit dt,
                              input bit fl, input bit ce);
    bit pop, done, ovf_set;
    logic [127:0] blk;
    pop = marmed && dt && (mfifo.size() > 0);
    done = 1'b0;
    ovf_set = 1'b0;
    blk = 128'd0;
    if (se && !fl) begin
      mq.push_back(d);
      if (mq.size() == mbits) begin
        blk = form_block();
        mq.delete();
        done = 1'b1;
      end
    end
    if (fl) mq.delete();
    if (pop) mfifo.delete(0);
    if (done) begin
      if (mfifo.size() < MDEPTH) mfifo.push_back(blk);
      else ovf_set = 1'b1;
    end
    if (ovf_set) movf = 1'b1;
    else if (ce) movf = 1'b0;
    if (se && !ck) mferr = 1'b1;
    else if (ce) mferr = 1'b0;
    if (pop) marmed = 1'b0;
    else if (!dt) marmed = 1'b1;
  endtask

  task automatic compare();
    logic [127:0] e_head, o_out;
    logic o_rdy, o_ovf, o_ferr;
    logic [1:0] o_cnt;
    e_head = (mfifo.size() > 0) ? mfifo[0] : 128'd0;
    if (sel == 0) begin
      o_out = d0_out; o_rdy = d0_rdy; o_cnt = d0_cnt; o_ovf = d0_ovf; o_ferr = d0_ferr;
    end else begin
      o_out = {96'd0, d1_out}; o_rdy = d1_rdy; o_cnt = d1_cnt; o_ovf = d1_ovf; o_ferr = d1_ferr;
    end
    chk("data_out", o_out, e_head);
    chk("data_ready", 128'(o_rdy), 128'(mfifo.size() > 0));
    chk("block_count", 128'(o_cnt), 128'(mfifo.size()));
    chk("overflow", 128'(o_ovf), 128'(movf));
    chk("framing_err", 128'(o_ferr), 128'(mferr));
  endtask

  task automatic step(input bit se, input bit d, input bit ck, input bit dt,
                      input bit fl, input bit ce);
    if (sel == 0) begin
      d0_se = se; d0_dat = d; d0_ck = ck; d0_dt = dt; d0_fl = fl; d0_ce = ce;
      d1_se = 1'b0; d1_dat = 1'b0; d1_ck = 1'b1; d1_dt = 1'b0; d1_fl = 1'b0; d1_ce = 1'b0;
    end else begin
      d1_se = se; d1_dat = d; d1_ck = ck; d1_dt = dt; d1_fl = fl; d1_ce = ce;
      d0_se = 1'b0; d0_dat = 1'b0; d0_ck = 1'b1; d0_dt = 1'b0; d0_fl = 1'b0; d0_ce = 1'b0;
    end
    @(posedge clk);
    model_update(se, d, ck, dt, fl, ce);
    @(negedge clk);
    compare();
  endtask

  task automatic send_bit_of(input logic [7:0] b, input int i, input bit dt);
    step(1'b1, mlsb ? b[i] : b[7-i], 1'b1, dt, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit_of(b, i, 1'b0);
  endtask

  task automatic send_block(input logic [127:0] blk);
    for (int k = 0; k < mbits / 8; k++) send_byte(blk[mbits-1-8*k -: 8]);
  endtask

  task automatic take();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_run(input int cycles, input int rst_at);
    bit se, d, ck, dt, fl, ce;
    for (int c = 0; c < cycles; c++) begin
      if (c == rst_at) async_reset();
      se = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      ck = ($urandom_range(0, 31) != 0);
      if (((c / 300) % 2) == 0) dt = ($urandom_range(0, 4) == 0);
      else dt = ($urandom_range(0, 399) == 0);
      fl = ($urandom_range(0, 199) == 0);
      ce = ($urandom_range(0, 63) == 0);
      step(se, d, ck, dt, fl, ce);
    end
  endtask

  initial begin
    logic [127:0] b1, b2, b3, b4, blk;
    sel = 0; mbits = 128; mlsb = 1'b1;
    d0_se = 1'b0; d0_dat = 1'b0; d0_ck = 1'b1; d0_dt = 1'b0; d0_fl = 1'b0; d0_ce = 1'b0;
    d1_se = 1'b0; d1_dat = 1'b0; d1_ck = 1'b1; d1_dt = 1'b0; d1_fl = 1'b0; d1_ce = 1'b0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 compare();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Known block, default configuration
    send_block(128'h1234567890abcdef1234567890abcdef);
    chk("req035_rdy", 128'(d0_rdy), 128'd1);
    chk("req035_data", d0_out, 128'h1234567890abcdef1234567890abcdef);
    chk("req035_cnt", 128'(d0_cnt), 128'd1);
    take();
    chk("req036_rdy", 128'(d0_rdy), 128'd0);
    chk("req036_cnt", 128'(d0_cnt), 128'd0);
    for (int j = 0; j < 8; j++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      send_block(blk);
      chk("req036_blk", d0_out, blk);
      take();
      chk("req036_empty", 128'(d0_cnt), 128'd0);
    end

    // Backup, overflow and clear
    b1 = {$urandom, $urandom, $urandom, $urandom};
    b2 = {$urandom, $urandom, $urandom, $urandom};
    b3 = {8'h3d, 8'h48, 16'($urandom), $urandom, $urandom, $urandom};
    send_block(b1);
    send_block(b2);
    send_byte(8'h3d);
    send_byte(8'h48);
    chk("req037_cnt", 128'(d0_cnt), 128'd2);
    chk("req037_ovf", 128'(d0_ovf), 128'd0);
    for (int k = 2; k < 16; k++) send_byte(b3[127-8*k -: 8]);
    chk("req038_ovf", 128'(d0_ovf), 128'd1);
    chk("req038_head", d0_out, b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("req038_clr", 128'(d0_ovf), 128'd0);

    // Pop on the final strobe while full
    b4 = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 15; k++) send_byte(b4[127-8*k -: 8]);
    for (int i = 0; i < 7; i++) send_bit_of(b4[7:0], i, 1'b0);
    send_bit_of(b4[7:0], 7, 1'b1);
    chk("req039_cnt", 128'(d0_cnt), 128'd2);
    chk("req039_head", d0_out, b2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    take();
    chk("req039_tail", d0_out, b4);
    take();

    random_run(2400, 900);

    // 32-bit block, MSB-first configuration
    sel = 1; mbits = 32; mlsb = 1'b0;
    async_reset();
    send_block({96'd0, 32'hA5C30F81});
    chk("req040_data", 128'(d1_out), 128'h0000_0000_0000_0000_0000_0000_A5C3_0F81);
    take();
    send_byte(8'h5a);
    for (int i = 0; i < 4; i++) send_bit_of(8'hff, i, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_block({96'd0, 32'hA5C30F81});
    chk("req040_flush", 128'(d1_out), 128'h0000_0000_0000_0000_0000_0000_A5C3_0F81);
    chk("req040_cnt", 128'(d1_cnt), 128'd1);
    take();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("req040_ferr", 128'(d1_ferr), 128'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("req040_ferr_clr", 128'(d1_ferr), 128'd0);
    random_run(900, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
